tdc_sample_buffer: RTL and testbench
====================================

TDC_SAMPLE_BUFFER -- requirements
Module: tdc_sample_buffer

Interface
REQ-001 Parameter: N_DELAY, default 16, width of the thermometer code from the delay line.
REQ-002 Parameter: LOG2_AVG, default 2, log2 of the number of samples summed per result (legal 0..4).
REQ-003 Parameter: FIFO_DEPTH, default 4, number of result entries buffered (power of two).
REQ-004 Port: clk  input  1  single system clock; all state is on its rising edge.
REQ-005 Port: rst  input  1  reset; synchronous, active-high.
REQ-006 Port: time_count  input  N_DELAY  thermometer code from tdc_delay; held stable by upstream around each sample strobe.
REQ-007 Port: sample  input  1  asynchronous capture strobe from a pad; a rising edge requests one sample.
REQ-008 Port: out_data  output  8  readout byte.
REQ-009 Port: out_valid  output  1  out_data holds a valid byte.
REQ-010 Port: out_ready  input  1  consumer accepts the byte when out_valid and out_ready are high on the same edge.
REQ-011 Port: fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 Port: overflow  output  1  sticky flag: at least one result was dropped.
REQ-013 Port: busy  output  1  high while a partial accumulation is in progress.

Function
REQ-014 sample SHALL pass through a 2-flop synchronizer plus one edge-detect flop; a rising edge is detected 3 clk edges after sample rises (synchronizer-aligned).
REQ-015 On the detect cycle, time_count SHALL be registered and its popcount (0..N_DELAY, bubble-tolerant) computed in the following cycle.
REQ-016 Accumulator SHALL be 12 bits, unsigned, zero-extending each popcount; no saturation is needed (16*16=256 < 4096).
REQ-017 FSM states: IDLE, ACCUM, PUSH.
REQ-018 IDLE -> ACCUM on first popcount; accumulator loaded with it; sample counter = 1; busy = 1.
REQ-019 ACCUM: each further popcount adds to the accumulator and increments the counter; when the counter reaches 2^LOG2_AVG the FSM SHALL go to PUSH.
REQ-020 LOG2_AVG = 0: IDLE goes directly to PUSH after one popcount.
REQ-021 PUSH (one cycle): sum written to the FIFO, accumulator and counter cleared, busy = 0, FSM -> IDLE.
REQ-022 Sample edges arriving while in PUSH SHALL be held in a one-entry pending flag and consumed in IDLE; edges are never lost unless two arrive during one PUSH.
REQ-023 PUSH with FIFO full and no pop in the same cycle: result dropped, overflow set to 1; overflow is cleared only by rst.
REQ-024 PUSH with FIFO full and a pop in the same cycle: push SHALL succeed; overflow unchanged.
REQ-025 out_valid = FIFO non-empty.
REQ-026 Each entry SHALL be read as two bytes: phase 0 out_data = sum[7:0], phase 1 out_data = {4'b0, sum[11:8]}.
REQ-027 The phase toggles on each accepted byte; the entry is popped on acceptance of phase 1.
REQ-028 out_data and phase SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-029 fifo_full = (count == FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH; the count field is log2(FIFO_DEPTH)+1 bits.
REQ-030 Latency: the first byte of a result is valid the cycle after PUSH.

Reset
REQ-031 rst high at a clk edge SHALL clear the synchronizer, edge flop, pending flag, accumulator, counter, FIFO pointers/count, byte phase and overflow; FSM -> IDLE.
REQ-032 Outputs during and after reset: out_data = 0, out_valid = 0, fifo_full = 0, overflow = 0, busy = 0.
REQ-033 Reset mid-accumulation or mid-readout SHALL discard partial sums and all buffered entries without emitting bytes.

Structure
REQ-034 A shared package tdc_pkg SHALL hold the state enum (IDLE/ACCUM/PUSH), SUM_W = 12 and the byte-phase constants.
REQ-035 The FIFO SHALL be a separate sub-module, tdc_result_fifo (width SUM_W, depth FIFO_DEPTH, push/pop/full/empty/count).
REQ-036 Popcount and FSM SHALL live in tdc_sample_buffer.

Verification
REQ-037 Defaults; 4 strobes with time_count = 16'h00FF (popcount 8) -> one entry, bytes 8'h20 then 8'h00.
REQ-038 4 strobes with time_count = 16'hFFFF -> bytes 8'h40, 8'h00; bubble code 16'h0F0F x4 -> 8'h20, 8'h00.
REQ-039 out_ready held 0; 5 full groups -> fifo_full = 1 after the 4th PUSH, overflow = 1 after the 5th; draining then yields exactly 4 entries.
REQ-040 FIFO full, out_ready = 1 timed so phase-1 acceptance coincides with PUSH -> no overflow, count stays 4.
REQ-041 rst asserted after 2 of 4 strobes -> busy = 0, out_valid = 0; 4 new strobes of 16'h0003 -> bytes 8'h08, 8'h00.
REQ-042 out_ready toggled randomly -> out_data stable while stalled, byte order low/high preserved for every entry.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC sample buffer.
//   state_t  : accumulation FSM states (IDLE / ACCUM / PUSH)
//   SUM_W    : width of an accumulated result
//   CNT_W    : width of the per-result sample counter (covers 2^4 = 16)
//   PHASE_*  : readout byte phase (low byte first, then high nibble)
package tdc_pkg;

    localparam int SUM_W = 12;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PUSH  = 2'd2
    } state_t;

    localparam logic PHASE_LO = 1'b0;
    localparam logic PHASE_HI = 1'b1;

endpackage

// File: rtl/tdc_result_fifo.sv
// Small synchronous FIFO holding accumulated TDC results.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data (accepted when not full, or when full with a pop)
//   push_data   : result to store
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : head entry (combinational)
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
// DEPTH must be a power of two and at least 2; pointers wrap naturally.
module tdc_result_fifo
    import tdc_pkg::*;
#(
    parameter int WIDTH = SUM_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
    assign do_push = push & (~full | do_pop);

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tdc_sample_buffer.sv
// TDC sample buffer: synchronizes an asynchronous sample strobe, captures
// the delay-line thermometer code, sums 2^LOG2_AVG popcounts per result,
// buffers results in a FIFO and reads each result out as two bytes.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   time_count  : thermometer code from the delay line
//   sample      : asynchronous capture strobe (rising edge = one sample)
//   out_data    : readout byte (low byte, then {4'b0, high nibble})
//   out_valid   : out_data valid (FIFO non-empty)
//   out_ready   : consumer accepts the byte when high with out_valid
//   fifo_full   : FIFO holds FIFO_DEPTH entries
//   overflow    : sticky, a result was dropped on a full FIFO
//   busy        : partial accumulation in progress
//
// state | meaning
// IDLE  | no partial sum; next popcount starts a new result
// ACCUM | partial sum held, waiting for more popcounts
// PUSH  | one cycle: write sum to FIFO, clear accumulator
module tdc_sample_buffer
    import tdc_pkg::*;
#(
    parameter int N_DELAY    = 16,
    parameter int LOG2_AVG   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DELAY-1:0] time_count,
    input  logic               sample,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               fifo_full,
    output logic               overflow,
    output logic               busy
);

    localparam int PW = $clog2(N_DELAY + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] N_AVG = CNT_W'(1 << LOG2_AVG);

    logic               sync_0;
    logic               sync_1;
    logic               sync_d;
    logic               sample_edge;

    logic [N_DELAY-1:0] tc_reg;
    logic               tc_vld;
    logic [PW-1:0]      pop_cnt;

    logic               pend;
    logic               pend_next;
    logic [PW-1:0]      pend_cnt;
    logic [PW-1:0]      pend_cnt_next;
    logic               avail;
    logic [PW-1:0]      src;

    state_t             state;
    state_t             state_next;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               push;

    logic [SUM_W-1:0]   head;
    logic               fifo_full_int;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               phase;
    logic               accept;
    logic               pop_entry;

    // ---------------- strobe synchronizer and capture ----------------
    assign sample_edge = sync_1 & ~sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
            sync_d <= 1'b0;
            tc_reg <= '0;
            tc_vld <= 1'b0;
        end else begin
            sync_0 <= sample;
            sync_1 <= sync_0;
            sync_d <= sync_1;
            tc_vld <= sample_edge;
            if (sample_edge) tc_reg <= time_count;
        end
    end

    // Counting every set bit tolerates bubbles in the thermometer code.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            pop_cnt = pop_cnt + PW'(tc_reg[i]);
        end
    end

    // ---------------- accumulation FSM ----------------
    // A popcount that arrived during PUSH waits in the pending slot and is
    // consumed ahead of any newer one.
    assign avail = pend | tc_vld;
    assign src   = pend ? pend_cnt : pop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_cnt <= '0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            pend     <= pend_next;
            pend_cnt <= pend_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        acc_next      = acc;
        cnt_next      = cnt;
        pend_next     = pend;
        pend_cnt_next = pend_cnt;
        push          = 1'b0;

        case (state)
            IDLE: begin
                if (avail) begin
                    acc_next   = SUM_W'(src);
                    cnt_next   = CNT_W'(1);
                    state_next = (LOG2_AVG == 0) ? PUSH : ACCUM;
                    if (pend) begin
                        pend_next     = tc_vld;
                        pend_cnt_next = pop_cnt;
                    end
                end
            end
            ACCUM: begin
                if (avail) begin
                    acc_next = acc + SUM_W'(src);
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt + CNT_W'(1) == N_AVG) state_next = PUSH;
                    if (pend) begin
                        pend_next     = tc_vld;
                        pend_cnt_next = pop_cnt;
                    end
                end
            end
            PUSH: begin
                push       = 1'b1;
                acc_next   = '0;
                cnt_next   = '0;
                state_next = IDLE;
                if (tc_vld && !pend) begin
                    pend_next     = 1'b1;
                    pend_cnt_next = pop_cnt;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == ACCUM);

    // ---------------- result FIFO and byte readout ----------------
    tdc_result_fifo #(
        .WIDTH (SUM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (acc),
        .pop       (pop_entry),
        .pop_data  (head),
        .full      (fifo_full_int),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign accept    = out_valid & out_ready;
    assign pop_entry = accept & (phase == PHASE_HI);
    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));

    always_comb begin
        out_data = 8'h00;
        if (out_valid) begin
            out_data = (phase == PHASE_LO) ? head[7:0] : {4'b0000, head[SUM_W-1:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= PHASE_LO;
            overflow <= 1'b0;
        end else begin
            if (accept) phase <= ~phase;
            if (push && fifo_full_int && !pop_entry) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tdc_sample_buffer.sv
// Directed testbench for tdc_sample_buffer with default parameters.
module tb_tdc_sample_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] time_count;
    logic        sample;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        fifo_full;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdc_sample_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .time_count (time_count),
        .sample     (sample),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .busy       (busy)
    );

    typedef struct {
        logic [15:0] code [4];
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One strobe: rise, hold 3 cycles, low 3 cycles; code held throughout.
    task automatic strobe(input logic [15:0] code);
        time_count = code;
        sample = 1'b1;
        repeat (3) @(negedge clk);
        sample = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic group4(input logic [15:0] c0, input logic [15:0] c1,
                          input logic [15:0] c2, input logic [15:0] c3);
        strobe(c0);
        strobe(c1);
        strobe(c2);
        strobe(c3);
    endtask

    task automatic read_byte(input string name, input logic [7:0] exp);
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, " valid"}, 32'(out_valid), 1);
        check({name, " data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic read_entry(input string name, input logic [7:0] lo, input logic [7:0] hi);
        read_byte({name, " lo"}, lo);
        read_byte({name, " hi"}, hi);
    endtask

    // Raise the strobe for the last sample of a group and return in the PUSH
    // cycle (busy drops). found = 0 if PUSH was not seen within the budget.
    task automatic last_strobe_to_push(input logic [15:0] code, output bit found);
        found = 1'b0;
        time_count = code;
        sample = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_strobe();
        sample = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish, expected end within budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  exp_q [$];
        logic [7:0]  prev_data;
        bit          stalled;
        bit          found;
        logic [15:0] code;
        int          cycles;

        vecs[0].code = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF}; vecs[0].lo = 8'h20; vecs[0].hi = 8'h00;
        vecs[1].code = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; vecs[1].lo = 8'h40; vecs[1].hi = 8'h00;
        vecs[2].code = '{16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F}; vecs[2].lo = 8'h20; vecs[2].hi = 8'h00;
        vecs[3].code = '{16'h0003, 16'h0003, 16'h0003, 16'h0003}; vecs[3].lo = 8'h08; vecs[3].hi = 8'h00;
        vecs[4].code = '{16'hFFFF, 16'h0001, 16'h00FF, 16'h0000}; vecs[4].lo = 8'h19; vecs[4].hi = 8'h00;
        vecs[5].code = '{16'h8001, 16'h7FFE, 16'h0000, 16'hAAAA}; vecs[5].lo = 8'h18; vecs[5].hi = 8'h00;
        vecs[6].code = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}; vecs[6].lo = 8'h3C; vecs[6].hi = 8'h00;

        rst = 1'b1;
        sample = 1'b0;
        out_ready = 1'b0;
        time_count = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst out_data", 32'(out_data), 0);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst fifo_full", 32'(fifo_full), 0);
        check("rst overflow", 32'(overflow), 0);
        check("rst busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst out_valid", 32'(out_valid), 0);
        check("post-rst busy", 32'(busy), 0);

        // Table-driven single-result vectors.
        for (int v = 0; v < 7; v++) begin
            strobe(vecs[v].code[0]);
            strobe(vecs[v].code[1]);
            check($sformatf("vec%0d busy mid", v), 32'(busy), 1);
            strobe(vecs[v].code[2]);
            strobe(vecs[v].code[3]);
            check($sformatf("vec%0d busy done", v), 32'(busy), 0);
            read_entry($sformatf("vec%0d", v), vecs[v].lo, vecs[v].hi);
            check($sformatf("vec%0d drained", v), 32'(out_valid), 0);
        end

        // First byte valid the cycle after PUSH.
        strobe(16'hFFFF);
        strobe(16'hFFFF);
        strobe(16'hFFFF);
        last_strobe_to_push(16'hFFFF, found);
        check("latency push seen", 32'(found), 1);
        check("latency valid in PUSH", 32'(out_valid), 0);
        @(negedge clk);
        check("latency valid after PUSH", 32'(out_valid), 1);
        check("latency data", 32'(out_data), 32'h40);
        finish_strobe();
        read_entry("latency", 8'h40, 8'h00);

        // Back-to-back strobes every other cycle: no edge may be lost.
        time_count = 16'h00FF;
        for (int i = 0; i < 8; i++) begin
            sample = 1'b1;
            @(negedge clk);
            sample = 1'b0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("burst busy", 32'(busy), 0);
        read_entry("burst0", 8'h20, 8'h00);
        read_entry("burst1", 8'h20, 8'h00);
        check("burst drained", 32'(out_valid), 0);

        // Overflow: 5 groups with no reads; sums 4, 8, 12, 16, 20.
        for (int g = 0; g < 5; g++) begin
            code = (16'h0001 << (g + 1)) - 16'h0001;
            group4(code, code, code, code);
            if (g == 2) check("ovf full after 3", 32'(fifo_full), 0);
            if (g == 3) begin
                check("ovf full after 4", 32'(fifo_full), 1);
                check("ovf clear after 4", 32'(overflow), 0);
            end
            if (g == 4) begin
                check("ovf set after 5", 32'(overflow), 1);
                check("ovf still full", 32'(fifo_full), 1);
            end
        end
        read_entry("ovf e0", 8'h04, 8'h00);
        check("ovf not full after pop", 32'(fifo_full), 0);
        read_entry("ovf e1", 8'h08, 8'h00);
        read_entry("ovf e2", 8'h0C, 8'h00);
        read_entry("ovf e3", 8'h10, 8'h00);
        check("ovf drained", 32'(out_valid), 0);
        check("ovf sticky", 32'(overflow), 1);
        pulse_reset();
        check("ovf cleared by rst", 32'(overflow), 0);

        // Full FIFO with phase-1 acceptance coinciding with PUSH.
        for (int g = 0; g < 4; g++) begin
            code = (16'h0001 << (g + 1)) - 16'h0001;
            group4(code, code, code, code);
        end
        check("coinc full", 32'(fifo_full), 1);
        read_byte("coinc head lo", 8'h04);
        strobe(16'h003F);
        strobe(16'h003F);
        strobe(16'h003F);
        last_strobe_to_push(16'h003F, found);
        check("coinc push seen", 32'(found), 1);
        check("coinc head hi", 32'(out_data), 32'h00);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        finish_strobe();
        check("coinc no overflow", 32'(overflow), 0);
        check("coinc still full", 32'(fifo_full), 1);
        read_entry("coinc e1", 8'h08, 8'h00);
        read_entry("coinc e2", 8'h0C, 8'h00);
        read_entry("coinc e3", 8'h10, 8'h00);
        read_entry("coinc e4", 8'h18, 8'h00);
        check("coinc drained", 32'(out_valid), 0);

        // Reset mid-readout and mid-accumulation.
        group4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        read_byte("midrst lo", 8'h40);
        strobe(16'h0003);
        strobe(16'h0003);
        check("midrst busy before", 32'(busy), 1);
        check("midrst valid before", 32'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy in rst", 32'(busy), 0);
        check("midrst valid in rst", 32'(out_valid), 0);
        check("midrst data in rst", 32'(out_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst busy after", 32'(busy), 0);
        check("midrst valid after", 32'(out_valid), 0);
        group4(16'h0003, 16'h0003, 16'h0003, 16'h0003);
        read_entry("midrst new", 8'h08, 8'h00);
        check("midrst drained", 32'(out_valid), 0);

        // Random out_ready: stability while stalled, low/high order per entry.
        group4(16'h0001, 16'h0001, 16'h0001, 16'h0001);
        group4(16'h07FF, 16'h07FF, 16'h07FF, 16'h07FF);
        group4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF);
        exp_q = '{8'h04, 8'h00, 8'h2C, 8'h00, 8'h3F, 8'h00};
        stalled = 1'b0;
        prev_data = 8'h00;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 300) begin
            if (out_valid) begin
                if (stalled) check("rnd stall stable", 32'(out_data), 32'(prev_data));
                out_ready = 1'($urandom_range(0, 1));
                if (out_ready) check("rnd byte", 32'(out_data), 32'(exp_q.pop_front()));
                stalled = ~out_ready;
                prev_data = out_data;
            end else begin
                out_ready = 1'b0;
                stalled = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        check("rnd all bytes seen", 32'(exp_q.size()), 0);
        check("rnd drained", 32'(out_valid), 0);
        check("rnd no overflow", 32'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
